// File: rtl/alu_seq_if.sv
// Request/response bundle for alu_seq: operands and opcode in, registered result and status out.
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  // start is sampled only while busy=0; done pulses one cycle with result/psw_o valid,
  // and both outputs then hold until the next done.
  logic             start;
  logic [4:0]       instr;
  logic             instr_opt;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic [15:0]      psw_i;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [15:0]      psw_o;

  modport master (
    output start, instr, instr_opt, op1, op2, psw_i,
    input  busy, done, result, psw_o
  );

  modport slave (
    input  start, instr, instr_opt, op1, op2, psw_i,
    output busy, done, result, psw_o
  );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-step arithmetic/logic ops, nibble-serial DADD and bit-serial SRA/RRC.
module alu_seq #(
  parameter int WIDTH   = 16,
  parameter int SHIFT_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  alu_seq_if.slave   bus,
  output logic [1:0] dbg_state
);
  localparam int IDX_W = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH/4 + (1 << SHIFT_W)) + 1;
  localparam int WP1   = WIDTH + 1;

  localparam logic [3:0] OP_ADD  = 4'h0, OP_ADDC = 4'h1, OP_SUB = 4'h2, OP_SUBC = 4'h3,
                         OP_DADD = 4'h4, OP_CMP  = 4'h5, OP_XOR = 4'h6, OP_AND  = 4'h7,
                         OP_OR   = 4'h8, OP_BIT  = 4'h9, OP_BIC = 4'hA, OP_BIS  = 4'hB,
                         OP_SRA  = 4'hC, OP_RRC  = 4'hD;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, FIN = 2'd2} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_load;
  logic [WIDTH-1:0]   w, s, w_next, fsrc, alt_src, mask, b_src, arith_res, lres;
  logic               c, v, n, z, c_next, v_next, n_next, z_next, use_alt;
  logic [4:0]         instr_l;
  logic               opt_l;
  logic [15:0]        psw_l;
  logic [3:0]         op, op_in;
  logic               byte_m, op_valid, is_sub, cin, sa, sb, sr, arith_c, arith_v;
  logic [WIDTH:0]     sum_w;
  logic [8:0]         sum_b;
  logic [IDX_W-1:0]   bit_idx;
  logic [4:0]         nib;
  logic [3:0]         digit;
  logic               dcarry, sh_in;
  logic [SHIFT_W-1:0] sh_cnt_in;

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    bus.busy   = (state != IDLE);
    case (state)
      IDLE:    if (bus.start) state_next = EXEC;
      EXEC:    if (cnt == '0) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Number of EXEC cycles minus one; everything not iterative takes a single EXEC cycle.
  always_comb begin
    op_in     = bus.instr[4:1];
    sh_cnt_in = bus.op2[SHIFT_W-1:0];
    cnt_load  = '0;
    if (op_in == OP_DADD)
      cnt_load = bus.instr[0] ? CNT_W'(1) : CNT_W'(WIDTH/4 - 1);
    else if ((op_in == OP_SRA || op_in == OP_RRC) && sh_cnt_in != '0)
      cnt_load = CNT_W'(sh_cnt_in) - CNT_W'(1);
  end

  always_comb begin
    op       = instr_l[4:1];
    byte_m   = instr_l[0];
    op_valid = (op <= OP_RRC);
    is_sub   = (op == OP_SUB) || (op == OP_SUBC) || (op == OP_CMP);
    b_src    = is_sub ? ~s : s;
    cin      = (op == OP_ADD) ? 1'b0 : ((op == OP_ADDC || op == OP_SUBC) ? c : 1'b1);
    sum_w    = {1'b0, w} + {1'b0, b_src} + WP1'(cin);
    sum_b    = {1'b0, w[7:0]} + {1'b0, b_src[7:0]} + 9'(cin);
    arith_res = byte_m ? {w[WIDTH-1:8], sum_b[7:0]} : sum_w[WIDTH-1:0];
    arith_c  = byte_m ? sum_b[8] : sum_w[WIDTH];
    sa       = byte_m ? w[7] : w[WIDTH-1];
    sb       = byte_m ? b_src[7] : b_src[WIDTH-1];
    sr       = byte_m ? arith_res[7] : arith_res[WIDTH-1];
    arith_v  = (sa == sb) && (sr != sa);

    if (byte_m) bit_idx = (s > WIDTH'(7)) ? IDX_W'(7) : IDX_W'(s[2:0]);
    else        bit_idx = (s > WIDTH'(WIDTH - 1)) ? IDX_W'(WIDTH - 1) : s[IDX_W-1:0];
    mask          = '0;
    mask[bit_idx] = 1'b1;

    // One BCD digit per cycle; adding 6 mod 16 is the same as subtracting 10.
    nib    = {1'b0, w[3:0]} + {1'b0, s[3:0]} + 5'(c);
    dcarry = (nib > 5'd9);
    digit  = dcarry ? (nib[3:0] + 4'd6) : nib[3:0];
    sh_in  = (op == OP_SRA) ? (byte_m ? w[7] : w[WIDTH-1]) : c;

    w_next  = w;
    c_next  = c;
    v_next  = 1'b0;
    use_alt = 1'b0;
    alt_src = '0;
    lres    = '0;
    case (op)
      OP_ADD, OP_ADDC, OP_SUB, OP_SUBC: begin
        w_next = arith_res;
        c_next = arith_c;
        v_next = arith_v;
      end
      OP_CMP: begin
        c_next  = arith_c;
        v_next  = arith_v;
        use_alt = 1'b1;
        alt_src = arith_res;
      end
      OP_XOR, OP_AND, OP_OR: begin
        lres   = (op == OP_XOR) ? (w ^ s) : ((op == OP_AND) ? (w & s) : (w | s));
        w_next = byte_m ? {w[WIDTH-1:8], lres[7:0]} : lres;
      end
      OP_BIT: begin
        use_alt = 1'b1;
        alt_src = w & mask;
      end
      OP_BIC:  w_next = w & ~mask;
      OP_BIS:  w_next = w | mask;
      OP_DADD: begin
        w_next = byte_m ? {w[WIDTH-1:8], digit, w[7:4]} : {digit, w[WIDTH-1:4]};
        c_next = dcarry;
      end
      OP_SRA, OP_RRC: begin
        if (s[SHIFT_W-1:0] != '0) begin
          w_next = byte_m ? {w[WIDTH-1:8], sh_in, w[7:1]} : {sh_in, w[WIDTH-1:1]};
          c_next = w[0];
        end
      end
      default: ;
    endcase
    fsrc   = use_alt ? alt_src : w_next;
    n_next = byte_m ? fsrc[7] : fsrc[WIDTH-1];
    z_next = byte_m ? (fsrc[7:0] == 8'h00) : (fsrc == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      w          <= '0;
      s          <= '0;
      c          <= 1'b0;
      v          <= 1'b0;
      n          <= 1'b0;
      z          <= 1'b0;
      instr_l    <= '0;
      opt_l      <= 1'b0;
      psw_l      <= '0;
      bus.done   <= 1'b0;
      bus.result <= '0;
      bus.psw_o  <= '0;
    end else begin
      bus.done <= (state == FIN);
      case (state)
        IDLE: begin
          if (bus.start) begin
            w       <= bus.op1;
            s       <= bus.op2;
            c       <= bus.psw_i[0];
            v       <= 1'b0;
            n       <= 1'b0;
            z       <= 1'b0;
            instr_l <= bus.instr;
            opt_l   <= bus.instr_opt;
            psw_l   <= bus.psw_i;
            cnt     <= cnt_load;
          end
        end
        EXEC: begin
          w <= w_next;
          c <= c_next;
          v <= v_next;
          n <= n_next;
          z <= z_next;
          if (op == OP_DADD) s <= {4'h0, s[WIDTH-1:4]};
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
        end
        FIN: begin
          bus.result <= w;
          bus.psw_o  <= (opt_l && op_valid) ? {psw_l[15:5], v, psw_l[3], n, z, c} : psw_l;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 16, datapath width in bits; SHALL be a multiple of 8 and at least 16.
REQ-002 Parameter SHIFT_W, default 4, width of the shift-count field taken from op2.
REQ-003 clk  input  1  Single clock; all state SHALL change on its rising edge only.
REQ-004 rst  input  1  Reset, synchronous, active-high.
REQ-005 start  input  1  Request; SHALL be sampled only while busy=0.
REQ-006 instr  input  5  Opcode; bit0=1 selects byte mode.
REQ-007 instr_opt  input  1  1 = operation updates flags; 0 = flags pass through from psw_i.
REQ-008 op1  input  WIDTH  Destination operand.
REQ-009 op2  input  WIDTH  Source operand, or shift count in op2[SHIFT_W-1:0].
REQ-010 psw_i  input  16  Incoming status; bit0 C, bit1 Z, bit2 N, bit4 V.
REQ-011 busy  output  1  High from the cycle after an accepted start until the done cycle.
REQ-012 done  output  1  One-cycle pulse marking result/psw_o valid.
REQ-013 result  output  WIDTH  Registered result, held until the next done.
REQ-014 psw_o  output  16  Registered status, held until the next done.

Function
REQ-015 States SHALL be IDLE, EXEC, FIN; IDLE->EXEC on start&!busy, EXEC->FIN when the iteration count reaches zero, FIN->IDLE unconditionally.
REQ-016 Inputs SHALL be latched on acceptance; later input changes SHALL not affect the operation.
REQ-017 start while busy=1 SHALL be ignored, with no queuing.
REQ-018 Single-step ops (ADD 00000, ADDC 00010, SUB 00100, SUBC 00110, CMP 01010, XOR 01100, AND 01110, OR 10000, BIT 10010, BIC 10100, BIS 10110) and their byte forms SHALL assert done exactly 2 cycles after the start edge.
REQ-019 DADD (01000) SHALL process one BCD nibble per EXEC cycle, LSB first, rippling decimal carry: WIDTH/4 cycles word, 2 cycles byte; C = final decimal carry.
REQ-020 SRA (11000) and RRC (11010) SHALL shift one bit per EXEC cycle for N=op2[SHIFT_W-1:0] cycles; N=0 SHALL complete as a single-step op with result=op1 and C unchanged.
REQ-021 Multi-step shifts: C = last bit shifted out; SRA SHALL replicate the MSB; RRC SHALL rotate through C.
REQ-022 Byte mode SHALL operate on bits [7:0], take flags from bit 7, and pass op1[WIDTH-1:8] to result unchanged.
REQ-023 ADD/ADDC: C = carry out of the MSB; SUB/SUBC compute dst+~src+1 / dst+~src+C with C = carry out (1 = no borrow).
REQ-024 V SHALL be 1 iff the source and destination sign bits match and the result sign differs; SUB variants SHALL use the inverted source sign.
REQ-025 N = result MSB; Z = (result==0) over the active width; logic ops SHALL clear V and leave C unchanged.
REQ-026 CMP and BIT SHALL set flags from the internal difference or mask, with result=op1.
REQ-027 BIT, BIC and BIS SHALL use bit index op2 clamped to WIDTH-1 (word) or 7 (byte).
REQ-028 When instr_opt=0, psw_o SHALL equal latched psw_i; psw_i bits other than 0, 1, 2 and 4 SHALL always pass through.
REQ-029 Undefined opcodes SHALL complete as single-step with result=op1 and psw_o=psw_i.

Reset
REQ-030 rst=1 at a clock edge SHALL force IDLE, busy=0, done=0, result=0, psw_o=0, and clear the iteration counter.
REQ-031 Reset mid-operation SHALL abort without asserting done; start in the same cycle as rst SHALL be ignored.
REQ-032 The first start accepted after reset SHALL behave identically to one accepted from power-up.

Verification
REQ-033 WIDTH=16, ADD op1=0x7FFF op2=0x0001 instr_opt=1 -> done 2 cycles later, result=0x8000, V=1, N=1, Z=0, C=0.
REQ-034 SUB op1=0x0005 op2=0x0005 -> result=0x0000, Z=1, C=1, V=0; ADD.b op1=0x12FF op2=0x0001 -> result=0x1200, C=1, Z=1.
REQ-035 DADD op1=0x0999 op2=0x0001 C=0 -> done after 4 EXEC cycles, result=0x1000, C=0; DADD op1=0x9999 op2=0x0001 -> result=0x0000, C=1.
REQ-036 SRA op1=0x8003 op2=3 -> busy for 3 EXEC cycles, result=0xF000, C=0; RRC op1=0x0001 C=0 op2=1 -> result=0x0000, C=1.
REQ-037 Start DADD, pulse start again mid-operation, then assert rst mid-operation -> second start ignored, no done, outputs 0, next ADD completes correctly.
REQ-038 ADD with instr_opt=0 and psw_i=0x0013 -> psw_o=0x0013 and result correct.
